// File: rtl/ro_puf_sequencer_if.sv
// rtl/ro_puf_sequencer_if.sv - handshake, challenge, counter and response bundle for the RO PUF sequencer
interface ro_puf_sequencer_if #(
  parameter int NUM_BITS = 8,
  parameter int CNT_W    = 12
);
  logic                start;
  logic                abort;
  logic [3:0]          challenge_base;
  logic [3:0]          stride;
  logic [CNT_W-1:0]    cnt1;
  logic [CNT_W-1:0]    cnt2;
  logic [3:0]          select1;
  logic [3:0]          select2;
  logic                ro_enable;
  logic                ro_reset;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] response;
  logic [NUM_BITS-1:0] tie_mask;

  // Host side: issues runs and presents the RO counter values
  modport master (
    output start, abort, challenge_base, stride, cnt1, cnt2,
    input  select1, select2, ro_enable, ro_reset, busy, done, response, tie_mask
  );

  // Sequencer side
  modport slave (
    input  start, abort, challenge_base, stride, cnt1, cnt2,
    output select1, select2, ro_enable, ro_reset, busy, done, response, tie_mask
  );
endinterface

// File: rtl/ro_puf_sequencer.sv
// rtl/ro_puf_sequencer.sv - steps the RO PUF through challenge pairs and assembles response and tie mask
module ro_puf_sequencer #(
  parameter int NUM_BITS = 8,
  parameter int CNT_W    = 12,
  parameter int WINDOW   = 4095,
  parameter int SETTLE   = 4,
  parameter int SYNC_CYC = 3
) (
  input logic            clock,
  input logic            reset,
  ro_puf_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE_ST = 3'd1,
    MEASURE   = 3'd2,
    HOLD      = 3'd3,
    CAPTURE   = 3'd4,
    DONE      = 3'd5
  } state_t;

  // One shared phase counter times every fixed-length state, so size it for the longest one
  localparam int MAX_AB = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int MAXC   = (MAX_AB > SYNC_CYC) ? MAX_AB : SYNC_CYC;
  localparam int PW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE - 1);
  localparam logic [PW-1:0] WINDOW_LAST = PW'(WINDOW - 1);
  localparam logic [PW-1:0] SYNC_LAST   = PW'(SYNC_CYC - 1);
  localparam logic [3:0]    LAST_IDX    = 4'(NUM_BITS - 1);

  state_t              state, state_n;
  logic [PW-1:0]       phase;
  logic [3:0]          idx;
  logic [3:0]          base_q;
  logic [3:0]          stride_q;
  logic [NUM_BITS-1:0] shadow_resp, shadow_tie;
  logic [NUM_BITS-1:0] response_q, tie_q;
  logic [NUM_BITS-1:0] resp_next, tie_next;

  logic accept;
  logic do_capture;
  logic ro_enable_c, ro_reset_c, busy_c, done_c;
  logic cnt_ge, cnt_eq;

  // Abort wins over start, so an abort held in IDLE also blocks a new run
  assign accept     = (state == IDLE) && bus.start && !bus.abort;
  assign do_capture = (state == CAPTURE) && !bus.abort;

  // Counters are frozen by the time CAPTURE samples them; plain unsigned compare
  assign cnt_ge = (bus.cnt1 >= bus.cnt2);
  assign cnt_eq = (bus.cnt1 == bus.cnt2);

  // Merge the current bit into the shadows; loop avoids a width-mismatched bit select
  always_comb begin
    resp_next = shadow_resp;
    tie_next  = shadow_tie;
    for (int b = 0; b < NUM_BITS; b++) begin
      if (idx == 4'(b)) begin
        resp_next[b] = cnt_ge;
        tie_next[b]  = cnt_eq;
      end
    end
  end

  // Next-state and Moore control outputs
  always_comb begin
    state_n     = state;
    ro_enable_c = 1'b0;
    ro_reset_c  = 1'b1;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (accept) state_n = SETTLE_ST;
      end
      SETTLE_ST: begin
        ro_enable_c = 1'b1;
        if (phase == SETTLE_LAST) state_n = MEASURE;
      end
      MEASURE: begin
        ro_enable_c = 1'b1;
        ro_reset_c  = 1'b0;
        if (phase == WINDOW_LAST) state_n = HOLD;
      end
      HOLD: begin
        ro_reset_c = 1'b0;
        if (phase == SYNC_LAST) state_n = CAPTURE;
      end
      CAPTURE: begin
        ro_reset_c = 1'b0;
        state_n    = (idx == LAST_IDX) ? DONE : SETTLE_ST;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (bus.abort && (state != IDLE)) state_n = IDLE;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Phase counter restarts on every state change and only runs in timed states
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (state_n != state) begin
      phase <= '0;
    end else if ((state == SETTLE_ST) || (state == MEASURE) || (state == HOLD)) begin
      phase <= phase + PW'(1);
    end
  end

  // Challenge latch and bit index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q   <= 4'd0;
      stride_q <= 4'd0;
      idx      <= 4'd0;
    end else if (accept) begin
      base_q   <= bus.challenge_base;
      stride_q <= (bus.stride == 4'd0) ? 4'd1 : bus.stride;
      idx      <= 4'd0;
    end else if (do_capture && (idx != LAST_IDX)) begin
      idx <= idx + 4'd1;
    end
  end

  // Per-bit shadows; the visible response only moves on the edge into DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_resp <= '0;
      shadow_tie  <= '0;
      response_q  <= '0;
      tie_q       <= '0;
    end else begin
      if (accept) begin
        shadow_resp <= '0;
        shadow_tie  <= '0;
      end else if (do_capture) begin
        shadow_resp <= resp_next;
        shadow_tie  <= tie_next;
        if (idx == LAST_IDX) begin
          response_q <= resp_next;
          tie_q      <= tie_next;
        end
      end
    end
  end

  // Stride is forced non-zero at latch time, so the two selects never coincide
  assign bus.select1   = base_q + idx;
  assign bus.select2   = base_q + idx + stride_q;
  assign bus.ro_enable = ro_enable_c;
  assign bus.ro_reset  = ro_reset_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.response  = response_q;
  assign bus.tie_mask  = tie_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// tb/tb_ro_puf_sequencer.sv - directed self-checking bench for ro_puf_sequencer
module tb_ro_puf_sequencer;
  localparam int NB = 4;
  localparam int CW = 12;
  localparam int PER_BIT = 2 + 16 + 3 + 1;
  localparam int RUN_LEN = NB * PER_BIT + 1;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  logic [CW-1:0] tab1 [16];
  logic [CW-1:0] tab2 [16];

  ro_puf_sequencer_if #(.NUM_BITS(NB), .CNT_W(CW)) bus ();

  ro_puf_sequencer #(
    .NUM_BITS(NB), .CNT_W(CW), .WINDOW(16), .SETTLE(2), .SYNC_CYC(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Counter stub: values appear only once the ROs are frozen, zero otherwise
  always_comb begin
    if (!bus.ro_enable && !bus.ro_reset) begin
      bus.cnt1 = tab1[bus.select1];
      bus.cnt2 = tab2[bus.select2];
    end else begin
      bus.cnt1 = '0;
      bus.cnt2 = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full run: every cycle's controls and selects against a hand-derived schedule
  task automatic do_run(input logic [3:0] base, input logic [3:0] strd,
                        input logic [3:0] er, input logic [3:0] et, input bit mid_start);
    logic [3:0] se;
    logic [3:0] ctl_exp;
    logic [7:0] sel_exp;
    logic [3:0] s1, s2;
    int t, b, p;
    se = (strd == 4'd0) ? 4'd1 : strd;
    @(negedge clock);
    bus.start          = 1'b1;
    bus.challenge_base = base;
    bus.stride         = strd;
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 1; k <= RUN_LEN; k++) begin
      if (k > 1) @(negedge clock);
      if (mid_start && k == 30) begin
        bus.start          = 1'b1;
        bus.challenge_base = 4'd9;
        bus.stride         = 4'd5;
      end
      if (mid_start && k == 31) bus.start = 1'b0;
      t = k - 1;
      if (t < NB * PER_BIT) begin
        b = t / PER_BIT;
        p = t % PER_BIT;
        ctl_exp = {1'b1, 1'b0, (p < 18) ? 1'b1 : 1'b0, (p < 2) ? 1'b1 : 1'b0};
        s1 = base + 4'(b);
        s2 = base + 4'(b) + se;
        sel_exp = {s1, s2};
        chk("selects", {24'd0, bus.select1, bus.select2}, {24'd0, sel_exp});
      end else begin
        ctl_exp = 4'b1101;
      end
      chk("ctl_busy_done_en_rst", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset},
          {28'd0, ctl_exp});
    end
    @(negedge clock);
    chk("post_run_ctl", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset}, 32'h1);
    chk("response", {28'd0, bus.response}, {28'd0, er});
    chk("tie_mask", {28'd0, bus.tie_mask}, {28'd0, et});
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    reset              = 1'b0;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.challenge_base = 4'd0;
    bus.stride         = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tab1[i] = 12'd50;
      tab2[i] = 12'd10;
    end

    // Reset state
    #1;
    chk("rst_ctl", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset}, 32'h1);
    chk("rst_sel", {24'd0, bus.select1, bus.select2}, 32'h0);
    chk("rst_resp", {24'd0, bus.response, bus.tie_mask}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Basic run: cnt1 > cnt2 everywhere
    do_run(4'd0, 4'd15, 4'b1111, 4'b0000, 1'b0);

    // Stride 0 with wrap, leaves response 1010
    tab1[14] = 12'd1;  tab2[15] = 12'd2;
    tab1[15] = 12'd9;  tab2[0]  = 12'd3;
    tab1[0]  = 12'd7;  tab2[1]  = 12'd8;
    tab1[1]  = 12'd20; tab2[2]  = 12'd11;
    do_run(4'd14, 4'd0, 4'b1010, 4'b0000, 1'b0);

    // Abort in MEASURE of bit 2
    @(negedge clock);
    bus.start          = 1'b1;
    bus.challenge_base = 4'd0;
    bus.stride         = 4'd1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (51) @(negedge clock);
    chk("abort_pre_measure", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset}, 32'hA);
    chk("abort_pre_sel", {28'd0, bus.select1}, 32'd2);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("abort_ctl", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset}, 32'h1);
    chk("abort_resp", {28'd0, bus.response}, 32'hA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    chk("abort_resp_hold", {28'd0, bus.response}, 32'hA);

    // Fresh run after abort: mixed compares and a tie, with an ignored mid-run start
    tab1[0] = 12'd100;  tab2[1] = 12'd200;
    tab1[1] = 12'd300;  tab2[2] = 12'd300;
    tab1[2] = 12'd4095; tab2[3] = 12'd0;
    tab1[3] = 12'd5;    tab2[4] = 12'd6;
    do_run(4'd0, 4'd1, 4'b0110, 4'b0010, 1'b1);

    // Asynchronous reset in HOLD of bit 0, between edges
    @(negedge clock);
    bus.start          = 1'b1;
    bus.challenge_base = 4'd3;
    bus.stride         = 4'd2;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (18) @(negedge clock);
    chk("hold_ctl", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset}, 32'h8);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ctl", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset}, 32'h1);
    chk("arst_resp", {24'd0, bus.response, bus.tie_mask}, 32'h0);
    chk("arst_sel", {24'd0, bus.select1, bus.select2}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_arst_idle", {28'd0, bus.busy, bus.done, bus.ro_enable, bus.ro_reset}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
